count_seq_checker: RTL and testbench
====================================

// Module: count_seq_checker
// PURPOSE
//   Downstream monitor for the 4-bit free-running counter. Samples its count
//   output every clock and checks that the value steps by +1 (mod 2^WIDTH).
//   Reports lock, wrap events (15->0) and a wrap tally. Flags illegal steps
//   (stalls, skips, jumps) with a sticky error and a saturating error count.
// PARAMETERS
//   WIDTH      4  width of the monitored count
//   WRAP_W     8  width of wrap_count
//   ERR_W      4  width of err_count (saturates at all-ones)
//   LOCK_N     3  consecutive good steps required to enter LOCKED (>=1)
// PORTS
//   clk         in   1        single clock, all logic on rising edge
//   reset       in   1        synchronous, active-low reset
//   count_in    in   WIDTH    counter value under check
//   count_valid in   1        1 = counter running, sample is meaningful
//   clear_err   in   1        1-cycle pulse: clear err_flag, leave FAULT
//   locked      out  1        1 while in LOCKED
//   wrap_pulse  out  1        1-cycle pulse per wrap seen while LOCKED
//   wrap_count  out  WRAP_W   wraps seen while LOCKED, rolls over
//   err_flag    out  1        sticky illegal-step flag
//   err_count   out  ERR_W    illegal steps seen, saturating
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=UNSYNC. All outputs 0. prev=0, run=0.
// - good step: count_in == prev+1 mod 2^WIDTH. Any other value is bad,
//   including count_in == prev (stall).
// - wrap: good step with prev == all-ones and count_in == 0.
// - All outputs are registered. An event sampled at edge N shows on the
//   outputs after edge N. Latency is 1 cycle.
// - prev <= count_in on every edge with count_valid=1, in every state.
// - FSM, evaluated on each edge:
//   UNSYNC : valid -> ACQUIRE, run<=0. !valid -> stay.
//   ACQUIRE: !valid -> UNSYNC.
//            good -> run<=run+1. If run+1==LOCK_N -> LOCKED.
//            bad -> run<=0, stay. Not counted as an error.
//   LOCKED : !valid -> UNSYNC. No error; the upstream counter reset is legal.
//            good -> stay. On wrap: wrap_pulse=1, wrap_count+=1.
//            bad -> FAULT, err_flag<=1, err_count+=1 (saturate).
//   FAULT  : clear_err -> UNSYNC, err_flag<=0. Otherwise stay, ignoring valid.
//            Bad steps in FAULT are not counted.
// - clear_err in UNSYNC/ACQUIRE/LOCKED clears err_flag only.
//   If clear_err and a bad step in LOCKED coincide, the error wins:
//   err_flag=1, FAULT.
// - err_count is never cleared by clear_err; only reset clears it.
//   It holds at 2^ERR_W-1.
// - wrap_count wraps from 2^WRAP_W-1 to 0 without a flag.
// - locked = (state==LOCKED), registered. wrap_pulse is 0 outside LOCKED.
// - Reset asserted mid-operation overrides every other input on that edge.
// TESTING
// T1 reset=0 for 2 clk with random count_in -> all outputs 0, locked=0.
// T2 reset=1, valid=1, count 0,1,2,3,... -> locked=1 after the 4th sample
//    (edge after count=3 with LOCK_N=3), err_flag=0.
// T3 locked, count runs 13,14,15,0,1 -> wrap_pulse=1 for exactly the cycle
//    after 0 is sampled; wrap_count 0->1; 20 full wraps -> wrap_count=20.
// T4 locked at count=6, then drive 6 (stall) -> FAULT, err_flag=1,
//    err_count=1, locked=0. Drive 9, 2 -> err_count stays 1.
//    clear_err -> UNSYNC, err_flag=0; re-locks after 4 good samples.
// T5 locked, drop count_valid for 1 cycle, then restart at 0 -> UNSYNC,
//    then re-locks, err_flag=0.
//    Repeat 16 forced faults with clear_err -> err_count saturates at 15.
// T6 locked, pulse reset=0 for 1 clk mid-count -> all outputs 0 next cycle.
//    Same edge as a bad step plus clear_err -> err_flag=1, FAULT.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Downstream monitor for a free-running WIDTH-bit counter. Samples the
//   counter every clock and checks that it steps by +1 (mod 2^WIDTH). After
//   LOCK_N consecutive good steps it reports lock. While locked it pulses and
//   tallies wraps (all-ones -> 0). An illegal step while locked raises a sticky
//   error, bumps a saturating error count and parks the monitor in FAULT until
//   clear_err is pulsed.
//
//   Ports
//     clk          in   1       single clock, rising edge
//     reset        in   1       synchronous, active-low reset
//     count_in     in   WIDTH   counter value under check
//     count_valid  in   1       counter running, sample meaningful
//     clear_err    in   1       pulse: clear err_flag, leave FAULT
//     locked       out  1       monitor is in LOCKED
//     wrap_pulse   out  1       one-cycle pulse per wrap seen while locked
//     wrap_count   out  WRAP_W  wraps seen while locked, rolls over
//     err_flag     out  1       sticky illegal-step flag
//     err_count    out  ERR_W   illegal steps seen, saturating
//
//   All outputs are registered: an event sampled on edge N is visible after
//   edge N.
module count_seq_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4,
    parameter int unsigned LOCK_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clear_err,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_count
);

    // run must be able to hold LOCK_N itself.
    localparam int unsigned      RUN_W    = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);

    typedef enum logic [1:0] {
        UNSYNC,
        ACQUIRE,
        LOCKED,
        FAULT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] run;

    logic [WIDTH-1:0] prev_inc;
    logic [RUN_W-1:0] run_inc;
    logic             good;
    logic             wrap;

    always_comb begin
        prev_inc = prev + 1'b1;
        run_inc  = run + 1'b1;
        // A stall (count_in == prev) is simply not equal to prev+1, so it is bad.
        good     = count_valid && (count_in == prev_inc);
        wrap     = good && (prev == '1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= UNSYNC;
            prev       <= '0;
            run        <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            err_flag   <= 1'b0;
            err_count  <= '0;
        end else begin
            wrap_pulse <= 1'b0;

            // prev tracks the counter in every state, FAULT included.
            if (count_valid) begin
                prev <= count_in;
            end

            // clear_err drops the flag everywhere; a coincident bad step in
            // LOCKED re-asserts it below, so the error wins.
            if (clear_err) begin
                err_flag <= 1'b0;
            end

            case (state)
                UNSYNC: begin
                    if (count_valid) begin
                        state <= ACQUIRE;
                        run   <= '0;
                    end
                end

                ACQUIRE: begin
                    if (!count_valid) begin
                        state <= UNSYNC;
                    end else if (good) begin
                        run <= run_inc;
                        if (run_inc == RUN_LOCK) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        run <= '0;
                    end
                end

                LOCKED: begin
                    if (!count_valid) begin
                        // Upstream counter stopped: legal, just resynchronise.
                        state  <= UNSYNC;
                        locked <= 1'b0;
                    end else if (good) begin
                        if (wrap) begin
                            wrap_pulse <= 1'b1;
                            wrap_count <= wrap_count + 1'b1;
                        end
                    end else begin
                        state    <= FAULT;
                        locked   <= 1'b0;
                        err_flag <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end

                FAULT: begin
                    if (clear_err) begin
                        state <= UNSYNC;
                    end
                end

                default: begin
                    state  <= UNSYNC;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
//   Directed bench for count_seq_checker. A behavioural model (integer
//   arithmetic, mod-16 counter rules) predicts every output each cycle; a
//   compare process checks the DUT against it on every falling edge, and the
//   stimulus sequence adds hand-computed literal checks at key points.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       clear_err;
    logic       locked;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       err_flag;
    logic [3:0] err_count;

    int checks = 0;
    int fails  = 0;

    count_seq_checker #(
        .WIDTH  (4),
        .WRAP_W (8),
        .ERR_W  (4),
        .LOCK_N (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .clear_err   (clear_err),
        .locked      (locked),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .err_flag    (err_flag),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 unsynchronised, 1 acquiring, 2 locked, 3 faulted
    int m_mode    = 0;
    int m_prev    = 0;
    int m_streak  = 0;
    int m_locked  = 0;
    int m_wp      = 0;
    int m_wc      = 0;
    int m_ef      = 0;
    int m_ec      = 0;
    bit started   = 1'b0;

    always @(posedge clk) begin
        int  v, c;
        bit  ok, wr;
        v = int'(count_valid);
        c = int'(count_in);
        if (reset === 1'b0) begin
            m_mode = 0; m_prev = 0; m_streak = 0;
            m_locked = 0; m_wp = 0; m_wc = 0; m_ef = 0; m_ec = 0;
            started = 1'b1;
        end else begin
            ok   = (v == 1) && (c == (m_prev + 1) % 16);
            wr   = ok && (m_prev == 15);
            m_wp = 0;
            if (clear_err) m_ef = 0;
            if (m_mode == 0) begin
                if (v == 1) begin m_mode = 1; m_streak = 0; end
            end else if (m_mode == 1) begin
                if (v == 0) m_mode = 0;
                else if (ok) begin
                    m_streak++;
                    if (m_streak == 3) m_mode = 2;
                end else m_streak = 0;
            end else if (m_mode == 2) begin
                if (v == 0) m_mode = 0;
                else if (ok) begin
                    if (wr) begin m_wp = 1; m_wc = (m_wc + 1) % 256; end
                end else begin
                    m_mode = 3;
                    m_ef   = 1;
                    m_ec   = (m_ec < 15) ? m_ec + 1 : 15;
                end
            end else begin
                if (clear_err) m_mode = 0;
            end
            if (v == 1) m_prev = c;
            m_locked = (m_mode == 2) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_locked",     32'(locked),     32'(m_locked));
            chk("cyc_wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
            chk("cyc_wrap_count", 32'(wrap_count), 32'(m_wc));
            chk("cyc_err_flag",   32'(err_flag),   32'(m_ef));
            chk("cyc_err_count",  32'(err_count),  32'(m_ec));
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] cur;

    task automatic drive(input logic rst, input logic v, input logic [3:0] c, input logic clr);
        reset       = rst;
        count_valid = v;
        count_in    = c;
        clear_err   = clr;
        @(negedge clk);
    endtask

    // Drive n consecutive good counter values starting at cur.
    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, cur, 1'b0);
            cur = cur + 4'd1;
        end
    endtask

    // From UNSYNC: samples 0,1,2,3 give lock; cur ends at 4.
    task automatic relock();
        cur = 4'd0;
        run_n(3);
        chk("relock_pre", 32'(locked), 32'd0);
        run_n(1);
        chk("relock", 32'(locked), 32'd1);
    endtask

    initial begin
        reset = 1'b0; count_valid = 1'b0; count_in = '0; clear_err = 1'b0;

        // T1: reset with random count input
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
        end
        chk("t1_locked",     32'(locked),     32'd0);
        chk("t1_wrap_pulse", 32'(wrap_pulse), 32'd0);
        chk("t1_wrap_count", 32'(wrap_count), 32'd0);
        chk("t1_err_flag",   32'(err_flag),   32'd0);
        chk("t1_err_count",  32'(err_count),  32'd0);

        // T2: lock after fourth sample
        cur = 4'd0;
        run_n(3);
        chk("t2_not_yet", 32'(locked), 32'd0);
        run_n(1);
        chk("t2_locked",  32'(locked),   32'd1);
        chk("t2_err",     32'(err_flag), 32'd0);

        // T3: wrap handling (cur = 4)
        run_n(12);                       // 4..15
        chk("t3_pre_wrap", 32'(wrap_pulse), 32'd0);
        run_n(1);                        // 0 sampled
        chk("t3_pulse",    32'(wrap_pulse), 32'd1);
        chk("t3_count1",   32'(wrap_count), 32'd1);
        run_n(1);                        // 1
        chk("t3_pulse_off", 32'(wrap_pulse), 32'd0);
        run_n(19 * 16);
        chk("t3_count20",  32'(wrap_count), 32'd20);

        // T4: stall fault (cur = 2)
        run_n(5);                        // 2..6
        drive(1'b1, 1'b1, 4'd6, 1'b0);   // stall
        chk("t4_err_flag",  32'(err_flag),  32'd1);
        chk("t4_err_count", 32'(err_count), 32'd1);
        chk("t4_locked",    32'(locked),    32'd0);
        drive(1'b1, 1'b1, 4'd9, 1'b0);
        drive(1'b1, 1'b1, 4'd2, 1'b0);
        chk("t4_no_count",  32'(err_count), 32'd1);
        drive(1'b1, 1'b0, 4'd0, 1'b1);   // clear_err
        chk("t4_cleared",   32'(err_flag),  32'd0);
        relock();

        // T5: valid drop is legal (cur = 4)
        run_n(2);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        chk("t5_drop_unlock", 32'(locked), 32'd0);
        relock();
        chk("t5_err_flag", 32'(err_flag), 32'd0);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, cur - 4'd1, 1'b0);  // stall
            drive(1'b1, 1'b0, 4'd0, 1'b1);
            relock();
        end
        chk("t5_saturated", 32'(err_count), 32'd15);

        // T6: mid-run reset, then bad step coinciding with clear_err (cur = 4)
        run_n(2);
        drive(1'b0, 1'b1, 4'd9, 1'b1);
        chk("t6_rst_locked", 32'(locked),     32'd0);
        chk("t6_rst_wc",     32'(wrap_count), 32'd0);
        chk("t6_rst_ec",     32'(err_count),  32'd0);
        relock();
        drive(1'b1, 1'b1, 4'd9, 1'b1);   // bad step + clear_err
        chk("t6_err_wins",   32'(err_flag),  32'd1);
        chk("t6_fault",      32'(locked),    32'd0);
        chk("t6_err_count",  32'(err_count), 32'd1);
        drive(1'b1, 1'b0, 4'd0, 1'b1);
        chk("t6_cleared",    32'(err_flag),  32'd0);
        relock();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
